// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the lw/sw/sub/xor/addi/srl/beq datapath.
// It takes a per-opcode path with optional wait padding, supports run/step control and halts on a zero word.
module stage_sequencer #(
  parameter int unsigned EX_WAIT = 2,
  parameter int unsigned WB_WAIT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      instruction,
  input  logic [6:0]       opcode,
  output logic [3:0]       state,
  output logic             busy,
  output logic             halted,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IF    = 4'b0000,
    S_ID    = 4'b0001,
    S_EX    = 4'b0010,
    S_MEM   = 4'b0011,
    S_WB    = 4'b0100,
    S_EXW   = 4'b0101,
    S_WBW   = 4'b0110,
    S_SUMPC = 4'b1000,
    S_FIM   = 4'b1001,
    S_IDLE  = 4'b1010
  } stage_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Wait counters preload with N-1 so the wait state is occupied exactly N cycles.
  localparam logic [3:0] EXW_LOAD = 4'(EX_WAIT - 1);
  localparam logic [3:0] WBW_LOAD = 4'(WB_WAIT - 1);

  stage_t     cur;
  logic [3:0] wait_cnt;
  logic       single;

  function automatic stage_t post_ex(input logic [6:0] op);
    if (op == OP_LW || op == OP_SW) return S_MEM;
    else if (op == OP_BEQ)          return S_SUMPC;
    else                            return S_WB;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_IDLE;
      wait_cnt    <= '0;
      single      <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (cur != S_IDLE && cur != S_FIM && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
      case (cur)
        S_IDLE: begin
          if (run) begin
            cur    <= S_IF;
            single <= 1'b0;
          end else if (step) begin
            cur    <= S_IF;
            single <= 1'b1;
          end
        end
        S_IF: cur <= S_ID;
        S_ID: cur <= (instruction == '0) ? S_FIM : S_EX;
        S_EX: begin
          if (EX_WAIT > 0) begin
            cur      <= S_EXW;
            wait_cnt <= EXW_LOAD;
          end else begin
            cur <= post_ex(opcode);
          end
        end
        S_EXW: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
          else                cur      <= post_ex(opcode);
        end
        S_MEM: cur <= (opcode == OP_SW) ? S_SUMPC : S_WB;
        S_WB: begin
          if (WB_WAIT > 0) begin
            cur      <= S_WBW;
            wait_cnt <= WBW_LOAD;
          end else begin
            cur <= S_SUMPC;
          end
        end
        S_WBW: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
          else                cur      <= S_SUMPC;
        end
        S_SUMPC: begin
          if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
          if (run && !single) begin
            cur <= S_IF;
          end else begin
            cur    <= S_IDLE;
            single <= 1'b0;
          end
        end
        S_FIM:   cur <= S_FIM;
        default: cur <= S_IDLE;
      endcase
    end
  end

  assign state  = cur;
  assign busy   = (cur != S_IDLE) && (cur != S_FIM);
  assign halted = (cur == S_FIM);
  assign retire = (cur == S_SUMPC);

endmodule
